// File: rtl/bq_sched.sv
// bq_sched: sequencer for a direct-form-I biquad. One signed multiplier and
// one accumulator are shared across the five taps, one tap per clock. The
// block owns the coefficient shadow/active banks and the delay line.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a sample; services a pending delay-line clear first
//   MAC   | one tap per cycle: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2
//   RND   | round, saturate, shift history, present the output
//   OUT   | hold out_data/out_sat until out_ready
module bq_sched #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sat,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_RND  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int PW = DW + CW;
  // Three guard bits: five products can never wrap the accumulator.
  localparam int AW = DW + CW + 3;

  localparam logic [CW-1:0]        COEF_ONE = CW'(2 ** FRAC);
  localparam logic signed [AW-1:0] RND_HALF = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] SAT_MAX  = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(2 ** (DW - 1)));

  logic [1:0]              state_q, state_d;
  logic [2:0]              tap_q;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [DW-1:0]    x_q, x1_q, x2_q, y1_q, y2_q;
  logic [CW-1:0]           shadow_q [5];
  logic [CW-1:0]           active_q [5];
  logic                    clr_pend_q, clr_pend_d;
  logic                    out_valid_q;
  logic [DW-1:0]           out_data_q;
  logic                    out_sat_q;

  logic signed [CW-1:0]    coef;
  logic signed [DW-1:0]    opnd;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    term;
  logic signed [AW-1:0]    rnd_sum;
  logic signed [AW-1:0]    rnd_r;
  logic signed [DW-1:0]    sat_val;
  logic                    sat_hit;

  assign in_ready  = (state_q == S_IDLE) && !clr_pend_q && !wb_rst_i;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Select the coefficient/operand pair for the current tap and accumulate.
  always_comb begin
    coef = '0;
    opnd = '0;
    case (tap_q)
      3'd0: begin coef = active_q[0]; opnd = x_q;  end
      3'd1: begin coef = active_q[1]; opnd = x1_q; end
      3'd2: begin coef = active_q[2]; opnd = x2_q; end
      3'd3: begin coef = active_q[3]; opnd = y1_q; end
      3'd4: begin coef = active_q[4]; opnd = y2_q; end
      default: ;
    endcase
    prod  = PW'(coef) * PW'(opnd);
    term  = AW'(prod);
    acc_d = (tap_q >= 3'd3) ? (acc_q - term) : (acc_q + term);
  end

  // Round half toward +inf via arithmetic shift, then clamp to DW bits.
  always_comb begin
    rnd_sum = acc_q + RND_HALF;
    rnd_r   = rnd_sum >>> FRAC;
    sat_hit = 1'b1;
    if (rnd_r > SAT_MAX) begin
      sat_val = SAT_MAX[DW-1:0];
    end else if (rnd_r < SAT_MIN) begin
      sat_val = SAT_MIN[DW-1:0];
    end else begin
      sat_val = rnd_r[DW-1:0];
      sat_hit = 1'b0;
    end
  end

  // Next state and delay-line clear request tracking.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid && in_ready) state_d = S_MAC;
      S_MAC:  if (tap_q == 3'd4) state_d = S_RND;
      S_RND:  state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    clr_pend_d = clr_pend_q;
    if (cfg_we && cfg_addr == 3'd5) begin
      clr_pend_d = 1'b1;
    end else if (state_q == S_IDLE && clr_pend_q) begin
      clr_pend_d = 1'b0;
    end
  end

  // Datapath, banks and history registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      clr_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= (i == 0) ? COEF_ONE : '0;
        active_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      case (cfg_addr)
        3'd0: if (cfg_we) shadow_q[0] <= cfg_wdata;
        3'd1: if (cfg_we) shadow_q[1] <= cfg_wdata;
        3'd2: if (cfg_we) shadow_q[2] <= cfg_wdata;
        3'd3: if (cfg_we) shadow_q[3] <= cfg_wdata;
        3'd4: if (cfg_we) shadow_q[4] <= cfg_wdata;
        default: ;
      endcase
      case (state_q)
        S_IDLE: begin
          if (clr_pend_q) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
          end else if (in_valid) begin
            x_q   <= in_data;
            acc_q <= '0;
            tap_q <= '0;
            for (int i = 0; i < 5; i++) active_q[i] <= shadow_q[i];
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + 3'd1;
        end
        S_RND: begin
          out_data_q  <= sat_val;
          out_sat_q   <= sat_hit;
          out_valid_q <= 1'b1;
          x2_q        <= x1_q;
          x1_q        <= x_q;
          y2_q        <= y1_q;
          y1_q        <= sat_val;
        end
        S_OUT: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bq_sched.sv
// Directed bench for bq_sched: reset state, pass-through, FIR, IIR feedback,
// saturation, backpressure/shadowing, delay-line clear and mid-sample reset.
module tb_bq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bq_sched #(.DW(16), .CW(16), .FRAC(14)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic write_cfg(input logic [2:0] a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = 16'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Push one sample and wait (bounded) for its result. wr_mode 1 issues a
  // cfg write on the accept edge, wr_mode 2 issues it during MAC.
  // On timeout y/s stay X so the caller's comparison fails.
  task automatic run_sample(input int x, input int wr_mode, input logic [2:0] wa,
                            input int wd, output logic [15:0] y, output logic s,
                            output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'(x);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (wr_mode == 1) begin cfg_we = 1'b1; cfg_addr = wa; cfg_wdata = 16'(wd); end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    y = 'x; s = 1'bx; lat = 0;
    while (lat < 40) begin
      if (wr_mode == 2 && lat == 2) begin
        cfg_we = 1'b1; cfg_addr = wa; cfg_wdata = 16'(wd);
      end else begin
        cfg_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) begin
        y = out_data; s = out_sat;
        break;
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: out_valid=%b out_sat=%b busy=%b want 0 0 0", out_valid, out_sat, busy);
    end
    checks++;
    if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", $signed(out_data)); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_passthrough;
    logic [15:0] y; logic s; int lat;
    run_sample(1000, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(1000) || s !== 1'b0) begin errors++; $display("FAIL pass_pos: got %0d sat %b want 1000 sat 0", $signed(y), s); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL pass_latency: got %0d want 6", lat); end
    run_sample(-1000, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(-1000) || s !== 1'b0) begin errors++; $display("FAIL pass_neg: got %0d sat %b want -1000 sat 0", $signed(y), s); end
  endtask

  task automatic test_fir;
    int xs[4] = '{16384, 0, 0, 0};
    int ys[4] = '{8192, 8192, 8192, 0};
    logic [15:0] y; logic s; int lat;
    write_cfg(3'd0, 8192);
    write_cfg(3'd1, 8192);
    write_cfg(3'd2, 8192);
    write_cfg(3'd5, 0);
    for (int i = 0; i < 4; i++) begin
      run_sample(xs[i], 0, 3'd0, 0, y, s, lat);
      checks++;
      if (y !== 16'(ys[i]) || s !== 1'b0) begin
        errors++; $display("FAIL fir[%0d]: got %0d sat %b want %0d sat 0", i, $signed(y), s, ys[i]);
      end
    end
  endtask

  task automatic test_iir;
    int xs[4] = '{16384, 0, 0, 0};
    int ys[4] = '{16384, 8192, 4096, 2048};
    logic [15:0] y; logic s; int lat;
    write_cfg(3'd0, 16384);
    write_cfg(3'd1, 0);
    write_cfg(3'd2, 0);
    write_cfg(3'd3, -8192);
    write_cfg(3'd5, 0);
    for (int i = 0; i < 4; i++) begin
      run_sample(xs[i], 0, 3'd0, 0, y, s, lat);
      checks++;
      if (y !== 16'(ys[i]) || s !== 1'b0) begin
        errors++; $display("FAIL iir[%0d]: got %0d sat %b want %0d sat 0", i, $signed(y), s, ys[i]);
      end
    end
  endtask

  // b0=b1=1.0, a1=0.5. Third output exercises saturated feedback (y1=32767,
  // not 45000) and the +inf tie rounding of 13616.5.
  task automatic test_saturation;
    int xs[5] = '{30000, 30000, 0, -30000, -30000};
    int ys[5] = '{30000, 32767, 13617, -30000, -32768};
    logic ss[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] y; logic s; int lat;
    write_cfg(3'd1, 16384);
    write_cfg(3'd3, 8192);
    write_cfg(3'd5, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) write_cfg(3'd5, 0);
      run_sample(xs[i], 0, 3'd0, 0, y, s, lat);
      checks++;
      if (y !== 16'(ys[i]) || s !== ss[i]) begin
        errors++; $display("FAIL sat[%0d]: got %0d sat %b want %0d sat %b", i, $signed(y), s, ys[i], ss[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] y; logic s; int lat; int bad;
    write_cfg(3'd1, 0);
    write_cfg(3'd3, 0);
    write_cfg(3'd5, 0);
    out_ready = 1'b0;
    run_sample(1234, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(1234)) begin errors++; $display("FAIL bp_first: got %0d want 1234", $signed(y)); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cfg_we = (i == 3); cfg_addr = 3'd0; cfg_wdata = 16'(8192);
      in_valid = 1'b1; in_data = 16'(1000);
      if (out_valid !== 1'b1 || out_data !== 16'(1234) || out_sat !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    checks++;
    if (out_data !== 16'(1234)) begin errors++; $display("FAIL bp_after_write: got %0d want 1234", $signed(out_data)); end
    out_ready = 1'b1;
    run_sample(1000, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(500)) begin errors++; $display("FAIL bp_new_b0: got %0d want 500", $signed(y)); end
    run_sample(-1, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(0)) begin errors++; $display("FAIL round_neg_tie: got %0d want 0", $signed(y)); end
    run_sample(1, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(1)) begin errors++; $display("FAIL round_pos_tie: got %0d want 1", $signed(y)); end
  endtask

  task automatic test_same_edge_write;
    logic [15:0] y; logic s; int lat;
    run_sample(1000, 1, 3'd0, 16384, y, s, lat);
    checks++;
    if (y !== 16'(500)) begin errors++; $display("FAIL same_edge_old: got %0d want 500", $signed(y)); end
    run_sample(1000, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(1000)) begin errors++; $display("FAIL same_edge_next: got %0d want 1000", $signed(y)); end
  endtask

  task automatic test_clear_mid;
    logic [15:0] y; logic s; int lat;
    write_cfg(3'd1, 16384);
    write_cfg(3'd5, 0);
    run_sample(100, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(100)) begin errors++; $display("FAIL clr_pre: got %0d want 100", $signed(y)); end
    run_sample(200, 2, 3'd5, 0, y, s, lat);
    checks++;
    if (y !== 16'(300)) begin errors++; $display("FAIL clr_deferred: got %0d want 300", $signed(y)); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_idle_cycle: in_ready=%b busy=%b want 0 0", in_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_back: got %b want 1", in_ready); end
    run_sample(50, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(50)) begin errors++; $display("FAIL clr_history: got %0d want 50", $signed(y)); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] y; logic s; int lat;
    write_cfg(3'd0, 8192);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'(100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_state: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    run_sample(7, 0, 3'd0, 0, y, s, lat);
    checks++;
    if (y !== 16'(7) || s !== 1'b0) begin errors++; $display("FAIL rst_mid_b0: got %0d sat %b want 7 sat 0", $signed(y), s); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fir();
    test_iir();
    test_saturation();
    test_backpressure();
    test_same_edge_write();
    test_clear_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
